// File: rtl/axil_banked_bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_banked_bram_pkg
//  Description : Shared types and constants for the AXI-lite banked BRAM:
//                controller state encoding, arbitration memory encoding,
//                AXI response codes and a constant-foldable clog2.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_banked_bram_pkg;

   // Controller state encoding
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WRESP = 3'd2,
      READ  = 3'd3,
      RRESP = 3'd4
   } state_t;

   // Which channel won the most recent arbitration
   typedef enum logic {
      GRANT_WRITE = 1'b0,
      GRANT_READ  = 1'b1
   } grant_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Ceiling log2; returns 0 for values of 0 or 1
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage : axil_banked_bram_pkg
`default_nettype wire

// File: rtl/axil_banked_bram_if.sv
`default_nettype none
// ============================================================================
//  Module      : axil_banked_bram_if
//  Description : AXI4-lite bus bundle (AW, W, B, AR, R channels) with
//                master and slave views.
//  Ports       : aw{addr,prot,valid,ready}, w{data,strb,valid,ready},
//                b{resp,valid,ready}, ar{addr,prot,valid,ready},
//                r{data,resp,valid,ready}
//  Revision    : 1.0 - initial release
// ============================================================================
interface axil_banked_bram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;

   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;

   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid,    input wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid,    output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input rready
   );
endinterface : axil_banked_bram_if
`default_nettype wire

// File: rtl/axil_banked_bram_ram.sv
`default_nettype none
// ============================================================================
//  Module      : bytewe_dual_ram
//  Description : True dual-port single-clock RAM, read-first on both ports.
//                Port A: full-word write. Port B: per-byte write enables.
//                Read data appears READ_LATENCY (1 or 2) cycles after the
//                address. No reset on contents or outputs.
//  Ports       : clk
//                i_a_we, i_a_addr, i_a_din, o_a_dout   (port A)
//                i_b_be, i_b_addr, i_b_din, o_b_dout   (port B)
//  Revision    : 1.0 - initial release
// ============================================================================
module bytewe_dual_ram #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    i_a_we,
   input  logic [ADDR_WIDTH-1:0]   i_a_addr,
   input  logic [DATA_WIDTH-1:0]   i_a_din,
   output logic [DATA_WIDTH-1:0]   o_a_dout,
   input  logic [DATA_WIDTH/8-1:0] i_b_be,
   input  logic [ADDR_WIDTH-1:0]   i_b_addr,
   input  logic [DATA_WIDTH-1:0]   i_b_din,
   output logic [DATA_WIDTH-1:0]   o_b_dout
);
   localparam int DEPTH      = 1 << ADDR_WIDTH;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_a_q;
   logic [DATA_WIDTH-1:0] r_b_q;

   // Reads sample the pre-write contents (read-first). Port A is written
   // after port B so that a same-address collision resolves to port A.
   always_ff @(posedge clk) begin
      r_a_q <= r_mem[i_a_addr];
      r_b_q <= r_mem[i_b_addr];
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (i_b_be[i]) begin
            r_mem[i_b_addr][i*8 +: 8] <= i_b_din[i*8 +: 8];
         end
      end
      if (i_a_we) begin
         r_mem[i_a_addr] <= i_a_din;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] r_a_q2;
         logic [DATA_WIDTH-1:0] r_b_q2;
         always_ff @(posedge clk) begin
            r_a_q2 <= r_a_q;
            r_b_q2 <= r_b_q;
         end
         assign o_a_dout = r_a_q2;
         assign o_b_dout = r_b_q2;
      end else begin : g_lat1
         assign o_a_dout = r_a_q;
         assign o_b_dout = r_b_q;
      end
   endgenerate

endmodule : bytewe_dual_ram
`default_nettype wire

// File: rtl/axil_banked_bram.sv
`default_nettype none
// ============================================================================
//  Module      : axil_banked_bram
//  Description : AXI4-lite slave in front of N_BANKS dual-port RAM banks.
//                AXI owns port B of every bank through a single-outstanding
//                controller; the FPGA fabric owns port A of each bank
//                directly, never stalled. Writes are refused (SLVERR) when
//                the bank is locked or the fabric writes the same word in
//                the same cycle.
//  Ports       : axi_clock           sole clock
//                rst                 asynchronous active-low reset
//                s_axil              AXI-lite slave bundle
//                bram_addr/din/we    packed per-bank fabric write/address
//                bram_dout           packed per-bank fabric read data
//                bank_lock           per-bank AXI write refusal
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_banked_bram
   import axil_banked_bram_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int N_BANKS      = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                          axi_clock,
   input  logic                          rst,
   axil_banked_bram_if.slave             s_axil,
   input  logic [N_BANKS*ADDR_WIDTH-1:0] bram_addr,
   input  logic [N_BANKS*DATA_WIDTH-1:0] bram_din,
   input  logic [N_BANKS-1:0]            bram_we,
   output logic [N_BANKS*DATA_WIDTH-1:0] bram_dout,
   input  logic [N_BANKS-1:0]            bank_lock
);
   localparam int   BANK_BITS_RAW = clog2(N_BANKS);
   localparam int   BANK_BITS     = (BANK_BITS_RAW < 1) ? 1 : BANK_BITS_RAW;
   localparam int   AXI_AW        = ADDR_WIDTH + BANK_BITS + 2;
   localparam int   STRB_WIDTH    = DATA_WIDTH / 8;
   localparam logic LAT_LAST      = 1'(READ_LATENCY - 1);

   state_t                  r_state;
   state_t                  w_state_next;
   grant_t                  r_last_grant;

   logic [ADDR_WIDTH-1:0]   r_word;
   logic [BANK_BITS-1:0]    r_bank;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_WIDTH-1:0]   r_wstrb;
   logic                    r_lat_cnt;
   logic [1:0]              r_bresp;
   logic [DATA_WIDTH-1:0]   r_rdata;

   logic [ADDR_WIDTH-1:0]   w_aw_word;
   logic [ADDR_WIDTH-1:0]   w_ar_word;
   logic [BANK_BITS-1:0]    w_aw_bank;
   logic [BANK_BITS-1:0]    w_ar_bank;
   logic                    w_wr_elig;
   logic                    w_rd_elig;
   logic                    w_grant_wr;
   logic                    w_grant_rd;
   logic                    w_awready;
   logic                    w_arready;
   logic                    w_wr_refused;
   logic [ADDR_WIDTH-1:0]   w_b_addr;
   logic [ADDR_WIDTH-1:0]   w_fpga_addr [N_BANKS];
   logic [STRB_WIDTH-1:0]   w_be        [N_BANKS];
   logic [DATA_WIDTH-1:0]   w_dout_b    [N_BANKS];
   logic                    w_unused_bits;

   // ------------------------------------------------------------------
   // Address decode: [1:0] byte offset, then word, then bank
   // ------------------------------------------------------------------
   assign w_aw_word = s_axil.awaddr[ADDR_WIDTH+1:2];
   assign w_ar_word = s_axil.araddr[ADDR_WIDTH+1:2];

   generate
      if (N_BANKS > 1) begin : g_multi_bank
         assign w_aw_bank = s_axil.awaddr[AXI_AW-1:ADDR_WIDTH+2];
         assign w_ar_bank = s_axil.araddr[AXI_AW-1:ADDR_WIDTH+2];
      end else begin : g_single_bank
         assign w_aw_bank = '0;
         assign w_ar_bank = '0;
      end
   endgenerate

   assign w_unused_bits = ^{s_axil.awprot, s_axil.arprot,
                            s_axil.awaddr[1:0], s_axil.araddr[1:0]};

   // ------------------------------------------------------------------
   // Arbitration: on a tie, whichever channel did not win last time wins.
   // rst gates eligibility so no ready is raised while reset is held.
   // ------------------------------------------------------------------
   assign w_wr_elig  = rst && (r_state == IDLE) && s_axil.awvalid && s_axil.wvalid;
   assign w_rd_elig  = rst && (r_state == IDLE) && s_axil.arvalid;
   assign w_grant_wr = w_wr_elig && (!w_rd_elig || (r_last_grant == GRANT_READ));
   assign w_grant_rd = w_rd_elig && !w_grant_wr;

   // ------------------------------------------------------------------
   // Controller: state register
   // ------------------------------------------------------------------
   always_ff @(posedge axi_clock or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Controller: next state and handshake strobes
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_awready    = 1'b0;
      w_arready    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_wr) begin
               w_awready    = 1'b1;
               w_state_next = WRITE;
            end else if (w_grant_rd) begin
               w_arready    = 1'b1;
               w_state_next = READ;
            end
         end
         WRITE: begin
            w_state_next = WRESP;
         end
         WRESP: begin
            if (s_axil.bready) begin
               w_state_next = IDLE;
            end
         end
         READ: begin
            if (r_lat_cnt == LAT_LAST) begin
               w_state_next = RRESP;
            end
         end
         RRESP: begin
            if (s_axil.rready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Write refusal: locked bank, or fabric writing the same word now
   // ------------------------------------------------------------------
   generate
      for (genvar b = 0; b < N_BANKS; b++) begin : g_fpga_addr
         assign w_fpga_addr[b] = bram_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
      end
   endgenerate

   assign w_wr_refused = bank_lock[r_bank] ||
                         (bram_we[r_bank] && (w_fpga_addr[r_bank] == r_word));

   // ------------------------------------------------------------------
   // Transaction registers and response capture
   // ------------------------------------------------------------------
   always_ff @(posedge axi_clock or negedge rst) begin
      if (!rst) begin
         r_last_grant <= GRANT_READ;
         r_word       <= '0;
         r_bank       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_lat_cnt    <= 1'b0;
         r_bresp      <= RESP_OKAY;
         r_rdata      <= '0;
      end else begin
         if (w_grant_wr) begin
            r_last_grant <= GRANT_WRITE;
            r_word       <= w_aw_word;
            r_bank       <= w_aw_bank;
            r_wdata      <= s_axil.wdata;
            r_wstrb      <= s_axil.wstrb;
         end else if (w_grant_rd) begin
            r_last_grant <= GRANT_READ;
            r_word       <= w_ar_word;
            r_bank       <= w_ar_bank;
         end

         if (r_state == READ) begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
         end else begin
            r_lat_cnt <= 1'b0;
         end

         if (r_state == WRITE) begin
            r_bresp <= w_wr_refused ? RESP_SLVERR : RESP_OKAY;
         end

         if ((r_state == READ) && (r_lat_cnt == LAT_LAST)) begin
            r_rdata <= w_dout_b[r_bank];
         end
      end
   end

   // In IDLE port B already points at the incoming read address so the
   // RAM read starts on the grant edge; otherwise it holds the latched word.
   assign w_b_addr = (r_state == IDLE) ? w_ar_word : r_word;

   // ------------------------------------------------------------------
   // Banks
   // ------------------------------------------------------------------
   generate
      for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
         assign w_be[b] = ((r_state == WRITE) && (r_bank == BANK_BITS'(b)) && !w_wr_refused)
                          ? r_wstrb : '0;

         bytewe_dual_ram #(
            .DATA_WIDTH   (DATA_WIDTH),
            .ADDR_WIDTH   (ADDR_WIDTH),
            .READ_LATENCY (READ_LATENCY)
         ) u_ram (
            .clk      (axi_clock),
            .i_a_we   (bram_we[b]),
            .i_a_addr (w_fpga_addr[b]),
            .i_a_din  (bram_din[b*DATA_WIDTH +: DATA_WIDTH]),
            .o_a_dout (bram_dout[b*DATA_WIDTH +: DATA_WIDTH]),
            .i_b_be   (w_be[b]),
            .i_b_addr (w_b_addr),
            .i_b_din  (r_wdata),
            .o_b_dout (w_dout_b[b])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // AXI outputs
   // ------------------------------------------------------------------
   assign s_axil.awready = w_awready;
   assign s_axil.wready  = w_awready;
   assign s_axil.arready = w_arready;
   assign s_axil.bvalid  = (r_state == WRESP);
   assign s_axil.bresp   = r_bresp;
   assign s_axil.rvalid  = (r_state == RRESP);
   assign s_axil.rresp   = RESP_OKAY;
   assign s_axil.rdata   = r_rdata;

endmodule : axil_banked_bram
`default_nettype wire

// File: doc/axil_banked_bram.md
AXIL_BANKED_BRAM -- requirements
Module: axil_banked_bram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI and BRAM word width; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width of each bank.
REQ-003 SHALL have parameter N_BANKS, default 4, number of banks; a power of two from 1 to 16. BANK_BITS = max(1, clog2(N_BANKS)).
REQ-004 SHALL have parameter READ_LATENCY, default 1, RAM read latency in cycles; 1 or 2.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; all other signals are synchronous to axi_clock.
REQ-006 Ports, with AW = ADDR_WIDTH+BANK_BITS+2:
- axi_clock  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- s_axil_aw{addr[AW],prot[3],valid in; ready out}  AXI-lite write address channel.
- s_axil_w{data[DATA_WIDTH],strb[DATA_WIDTH/8],valid in; ready out}  AXI-lite write data channel.
- s_axil_b{resp[2],valid out; ready in}  AXI-lite write response channel.
- s_axil_ar{addr[AW],prot[3],valid in; ready out}  AXI-lite read address channel.
- s_axil_r{data[DATA_WIDTH],resp[2],valid out; ready in}  AXI-lite read data channel.
- bram_addr  in  N_BANKS*ADDR_WIDTH  packed FPGA-side address, one per bank.
- bram_din  in  N_BANKS*DATA_WIDTH  packed FPGA-side write data.
- bram_we  in  N_BANKS  FPGA-side full-word write enable, one per bank.
- bram_dout  out  N_BANKS*DATA_WIDTH  FPGA-side read data, READ_LATENCY cycles after the address.
- bank_lock  in  N_BANKS  1 = AXI writes to that bank are refused.

Function
REQ-007 SHALL decode AXI address bits as [1:0] ignored, [ADDR_WIDTH+1:2] word address, [AW-1:ADDR_WIDTH+2] bank; when N_BANKS=1 the bank bit SHALL be ignored.
REQ-008 FSM states SHALL be IDLE, WRITE, WRESP, READ, RRESP.
REQ-009 In IDLE, a write SHALL be eligible only when awvalid and wvalid are both high; a read SHALL be eligible when arvalid is high.
REQ-010 When both are eligible in the same cycle, grant SHALL alternate using a last_grant register; after reset the write wins first.
REQ-011 A write grant SHALL pulse awready and wready together for one cycle and go to WRITE; a read grant SHALL pulse arready for one cycle and go to READ.
REQ-012 WRITE SHALL last one cycle, performing the RAM write with per-byte enables taken from wstrb; lanes whose strobe is 0 SHALL stay unchanged. The FSM then goes to WRESP.
REQ-013 WRESP SHALL hold bvalid high until bready; the FSM returns to IDLE in the handshake cycle. bresp SHALL be 2'b00, or 2'b10 per REQ-014/015.
REQ-014 If bank_lock[bank] is high in the WRITE cycle, the RAM SHALL NOT be written and bresp SHALL be 2'b10.
REQ-015 If in the WRITE cycle bram_we[bank]=1 and bram_addr[bank] equals the AXI word address, the FPGA write SHALL win, the AXI write SHALL be dropped, and bresp SHALL be 2'b10.
REQ-016 READ SHALL last READ_LATENCY cycles. rdata SHALL then be registered, rvalid SHALL go high, and the FSM SHALL enter RRESP.
REQ-017 In RRESP, rvalid and rdata SHALL hold stable until rready; the FSM returns to IDLE in the handshake cycle. rresp SHALL always be 2'b00.
REQ-018 A read of the same address written by the FPGA port in the same cycle SHALL return the old data (read-first).
REQ-019 FPGA ports SHALL be independent of the AXI FSM, with no stalls and no backpressure.
REQ-020 Minimum throughput SHALL be one transaction per 3 cycles (READ_LATENCY=1) or 4 cycles (READ_LATENCY=2) when bready/rready are held high.

Reset
REQ-021 While rst=0, state SHALL be IDLE; awready, wready, arready, bvalid and rvalid SHALL be 0; bresp, rresp and rdata SHALL be 0; last_grant SHALL be read.
REQ-022 Reset mid-transaction SHALL abort it with no response issued. The RAM write of an aborted WRITE cycle SHALL NOT occur if rst is low at the clock edge.
REQ-023 RAM contents and bram_dout SHALL NOT be reset.

Structure
REQ-024 Package axil_banked_bram_pkg SHALL hold the FSM state enum, RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, and a clog2 function.
REQ-025 Each bank SHALL instantiate one sub-module, bytewe_dual_ram: true dual-port, single clock, byte-write on port B, read-first, READ_LATENCY parameter, no reset.

Verification
REQ-026 Reset, then AXI write 0xDEADBEEF, wstrb 0xF, to byte address 0x0000_1004 (bank 1, word 1) -> bresp 00; AXI read of the same address returns 0xDEADBEEF; FPGA bank 1, addr 1 returns it READ_LATENCY cycles later.
REQ-027 Write 0x11223344, then wstrb 0x5 with data 0xAABBCCDD to the same address -> readback 0x11BB33DD.
REQ-028 aw/w/ar all valid in 3 consecutive IDLE windows -> grants in order W, R, W; each returns the correct response.
REQ-029 bank_lock[2]=1, AXI write 0x5 to bank 2, word 0 -> bresp 10, and a readback returns the prior value.
REQ-030 AXI write 0x1 and FPGA bram_we with 0x2 to bank 0, word 7 in the same WRITE cycle -> bresp 10; readback 0x2.
REQ-031 Hold rready=0 for 5 cycles -> rvalid and rdata stay stable. Deassert rst during WRESP -> bvalid drops immediately, and after release the FSM accepts a new write.
